neuron_mac: RTL and testbench
=============================

Name: neuron_mac

Overview:
- Sequential fixed-point multiply-accumulate neuron that computes one pre-activation value, act = bias + sum(x[k]*w[k]).
- Sits directly upstream of the sigmoid/activation stage and supplies its act_out operand.
- Inputs and weights arrive one pair per accepted beat over a valid/ready stream.
- The result is held behind a valid/ready output handshake and tagged with the neuron index it belongs to.

Parameters:
- DATA_W, 16, width of x, w and bias, signed Q8.8
- ACC_W, 40, accumulator width, signed Q24.16
- OUT_W, 32, result width, signed Q16.16, saturated
- N_MAX, 64, maximum inputs per neuron
- CNT_W, 7, width of count and index fields, at least clog2(N_MAX+1)

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous active-high reset
- start  input  1  begin a new neuron; accepted only in IDLE
- n_in  input  CNT_W  number of x/w pairs, sampled on accepted start
- bias  input  DATA_W  Q8.8 bias, sampled on accepted start
- idx_in  input  CNT_W  neuron index tag, sampled on accepted start
- in_valid  input  1  x_in/w_in valid
- in_ready  output  1  block accepts a beat
- x_in  input  DATA_W  Q8.8 input activation
- w_in  input  DATA_W  Q8.8 weight
- out_valid  output  1  act_out/idx_out valid
- out_ready  input  1  downstream consumes the result
- act_out  output  OUT_W  Q16.16 saturated pre-activation
- idx_out  output  CNT_W  latched idx_in
- busy  output  1  high in ACCUM or DONE

Behaviour:
- Reset: on rst=1 at a clock edge, state=IDLE and all of the following clear to 0: accumulator, beat counter, act_out, idx_out, out_valid, in_ready, busy.
  - rst has priority over every other input.
  - A reset mid-operation discards the partial sum and produces no output.
- States: IDLE, ACCUM, DONE.
- IDLE:
  - in_ready=0, out_valid=0.
  - On start=1, latch n_eff = min(n_in, N_MAX), idx_in, and acc = sign_extend(bias) << 8, i.e. bias converted to Q24.16. Clear the counter.
  - If n_eff==0, go to DONE; otherwise go to ACCUM.
- ACCUM:
  - in_ready=1.
  - Each cycle with in_valid&&in_ready: acc += sign_extend(x_in*w_in), where the full signed 32-bit Q16.16 product is extended to ACC_W; then count++.
  - When the accepted beat makes count==n_eff, go to DONE on the same edge. in_ready drops the following cycle, so at most n_eff beats are ever accepted.
  - in_valid=0 cycles stall with no effect.
- DONE:
  - out_valid=1.
  - act_out = acc saturated to OUT_W:
    - if acc > 2^(OUT_W-1)-1, act_out = 0x7FFFFFFF;
    - if acc < -2^(OUT_W-1), act_out = 0x80000000;
    - otherwise act_out = acc[OUT_W-1:0].
  - act_out and idx_out stay stable while out_valid=1 && out_ready=0.
  - On out_ready=1, return to IDLE; out_valid=0 the next cycle.
- Latency: out_valid rises the cycle after the last beat is accepted, or the cycle after start when n_eff==0.
- Minimum neuron time is n_eff+2 cycles, including the handshake cycle.
- start in ACCUM or DONE is ignored; its n_in, bias and idx_in are not sampled.
- A start in the same cycle as the DONE->IDLE handshake is also ignored. start is honoured only while state==IDLE.
- Accumulator does not wrap for N_MAX full-scale products: 64 * 2^30 < 2^39.
- in_ready, out_valid and busy are registered outputs with no combinational path from inputs.

Test Plan:
- Basic sum:
  - Stimulus: bias=0x0080 (0.5), n_in=3, x=0x0100,0x0200,0xFF00 (1, 2, -1), w=0x0200 (2) for all beats, idx_in=5.
  - Required: out_valid=1 the cycle after beat 3; act_out=0x00048000 (4.5); idx_out=5.
- Zero inputs: bias=0xFF80 (-0.5), n_in=0 -> out_valid one cycle after start; act_out=0xFFFF8000; no beats accepted.
- Saturation:
  - Stimulus: n_in=64, x=w=0x7FFF for all beats, bias=0x7FFF.
  - Required: act_out=0x7FFFFFFF.
  - Repeat with x=0x8000, w=0x7FFF; required act_out=0x80000000.
- Handshake stalls:
  - Stimulus: random in_valid gaps during ACCUM; hold out_ready=0 for 5 cycles in DONE.
  - Required: act_out/idx_out stable throughout; exactly n_in beats consumed; in_ready=0 after the last beat.
- Ignored start: pulse start with different bias/idx during ACCUM and during DONE -> result unchanged from the original neuron.
- Reset mid-op:
  - Stimulus: assert rst after 2 of 4 beats; then start a new neuron with bias=0, n_in=1, x=w=0x0100.
  - Required: all outputs 0 the cycle after rst; new result act_out=0x00010000, with no residue from the first neuron.

Source files
------------

// File: rtl/neuron_mac.sv
// Sequential fixed-point MAC neuron: act = bias + sum(x[k]*w[k]) in Q24.16,
// saturated to Q16.16 and presented with its neuron index over valid/ready.
module neuron_mac #(
    parameter int DATA_W = 16,
    parameter int ACC_W  = 40,
    parameter int OUT_W  = 32,
    parameter int N_MAX  = 64,
    parameter int CNT_W  = 7
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [CNT_W-1:0]  n_in,
    input  logic [DATA_W-1:0] bias,
    input  logic [CNT_W-1:0]  idx_in,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] x_in,
    input  logic [DATA_W-1:0] w_in,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [OUT_W-1:0]  act_out,
    output logic [CNT_W-1:0]  idx_out,
    output logic              busy
);

    typedef enum logic [1:0] {IDLE, ACCUM, DONE} state_t;

    localparam logic [CNT_W-1:0] N_MAX_C = CNT_W'(N_MAX);

    state_t                    state_q, state_d;
    logic signed [ACC_W-1:0]   acc_q, acc_d;
    logic [CNT_W-1:0]          cnt_q, cnt_d;
    logic [CNT_W-1:0]          n_eff_q, n_eff_d;
    logic [CNT_W-1:0]          idx_q, idx_d;
    logic [OUT_W-1:0]          act_q, act_d;
    logic                      in_ready_q, in_ready_d;
    logic                      out_valid_q, out_valid_d;
    logic                      busy_q, busy_d;

    logic signed [2*DATA_W-1:0] prod;
    logic signed [ACC_W-1:0]    acc_sum;
    logic signed [ACC_W-1:0]    bias_ext;

    // Bits above the Q16.16 sign bit must all match it, otherwise clamp.
    function automatic logic [OUT_W-1:0] saturate(input logic signed [ACC_W-1:0] a);
        logic [ACC_W-OUT_W:0] top;
        top = a[ACC_W-1:OUT_W-1];
        if (!a[ACC_W-1] && (|top))
            return {1'b0, {(OUT_W-1){1'b1}}};
        else if (a[ACC_W-1] && !(&top))
            return {1'b1, {(OUT_W-1){1'b0}}};
        else
            return a[OUT_W-1:0];
    endfunction

    assign prod     = $signed(x_in) * $signed(w_in);
    assign acc_sum  = acc_q + {{(ACC_W-2*DATA_W){prod[2*DATA_W-1]}}, prod};
    assign bias_ext = {{(ACC_W-DATA_W-8){bias[DATA_W-1]}}, bias, 8'b0};

    always_comb begin
        state_d     = state_q;
        acc_d       = acc_q;
        cnt_d       = cnt_q;
        n_eff_d     = n_eff_q;
        idx_d       = idx_q;
        act_d       = act_q;
        in_ready_d  = in_ready_q;
        out_valid_d = out_valid_q;
        busy_d      = busy_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    n_eff_d = (n_in > N_MAX_C) ? N_MAX_C : n_in;
                    idx_d   = idx_in;
                    acc_d   = bias_ext;
                    cnt_d   = '0;
                    busy_d  = 1'b1;
                    if (n_eff_d == '0) begin
                        state_d     = DONE;
                        out_valid_d = 1'b1;
                        act_d       = saturate(bias_ext);
                    end else begin
                        state_d    = ACCUM;
                        in_ready_d = 1'b1;
                    end
                end
            end
            ACCUM: begin
                if (in_valid && in_ready_q) begin
                    acc_d = acc_sum;
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_d == n_eff_q) begin
                        state_d     = DONE;
                        in_ready_d  = 1'b0;
                        out_valid_d = 1'b1;
                        act_d       = saturate(acc_sum);
                    end
                end
            end
            DONE: begin
                if (out_ready && out_valid_q) begin
                    state_d     = IDLE;
                    out_valid_d = 1'b0;
                    busy_d      = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            acc_q       <= '0;
            cnt_q       <= '0;
            n_eff_q     <= '0;
            idx_q       <= '0;
            act_q       <= '0;
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            acc_q       <= acc_d;
            cnt_q       <= cnt_d;
            n_eff_q     <= n_eff_d;
            idx_q       <= idx_d;
            act_q       <= act_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            busy_q      <= busy_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign act_out   = act_q;
    assign idx_out   = idx_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_neuron_mac.sv
// Scoreboard bench for neuron_mac: a driver pushes model results into a queue,
// a monitor pops and compares them whenever the DUT offers a result.
module tb_neuron_mac;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [6:0]  n_in;
    logic [15:0] bias;
    logic [6:0]  idx_in;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] x_in;
    logic [15:0] w_in;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] act_out;
    logic [6:0]  idx_out;
    logic        busy;

    neuron_mac dut (
        .clk(clk), .rst(rst), .start(start), .n_in(n_in), .bias(bias),
        .idx_in(idx_in), .in_valid(in_valid), .in_ready(in_ready),
        .x_in(x_in), .w_in(w_in), .out_valid(out_valid), .out_ready(out_ready),
        .act_out(act_out), .idx_out(idx_out), .busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] act;
        logic [6:0]  idx;
        int          hold;
    } exp_t;

    exp_t        sb[$];
    int          tests = 0;
    int          fails = 0;
    int          beat_cnt = 0;
    logic [15:0] xv[128];
    logic [15:0] wv[128];

    localparam longint MAXV = 64'sd2147483647;
    localparam longint MINV = -MAXV - 64'sd1;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        tests++;
        if (actual !== expected) begin
            fails++;
            $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
        end
    endtask

    // Reference: plain integer arithmetic on the real-valued Q formats.
    function automatic logic [31:0] model(input int neff, input logic [15:0] b);
        longint acc;
        acc = longint'($signed(b)) * 256;
        for (int k = 0; k < neff; k++)
            acc += longint'($signed(xv[k])) * longint'($signed(wv[k]));
        if (acc > MAXV) return 32'h7FFF_FFFF;
        if (acc < MINV) return 32'h8000_0000;
        return acc[31:0];
    endfunction

    always @(posedge clk)
        if (!rst && in_valid && in_ready) beat_cnt++;

    // Monitor: optionally back-pressures, checks hold stability, then pops.
    initial begin
        bit          holding = 0;
        int          hold_left = 0;
        logic [31:0] snap_act;
        logic [6:0]  snap_idx;
        exp_t        e;
        out_ready = 1'b0;
        forever begin
            @(negedge clk);
            if (rst) begin
                holding   = 0;
                out_ready = 1'b0;
            end else if (out_valid) begin
                if (!holding) begin
                    holding  = 1;
                    snap_act = act_out;
                    snap_idx = idx_out;
                    if (sb.size() == 0) begin
                        checkOutput("unexpected_valid", 32'(out_valid), 32'd0);
                        hold_left = 0;
                    end else begin
                        hold_left = sb[0].hold;
                    end
                end else begin
                    checkOutput("act_stable", act_out, snap_act);
                    checkOutput("idx_stable", 32'(idx_out), 32'(snap_idx));
                end
                if (hold_left == 0) begin
                    out_ready = 1'b1;
                    holding   = 0;
                    if (sb.size() > 0) begin
                        e = sb.pop_front();
                        checkOutput("act_out", act_out, e.act);
                        checkOutput("idx_out", 32'(idx_out), 32'(e.idx));
                    end
                end else begin
                    out_ready = 1'b0;
                    hold_left--;
                end
            end else begin
                out_ready = 1'b0;
            end
        end
    end

    task automatic waitIdle();
        int budget = 400;
        @(negedge clk);
        while ((busy || out_valid || sb.size() != 0) && budget > 0) begin
            @(negedge clk);
            budget--;
        end
        if (budget == 0) checkOutput("idle_timeout", 32'(busy | out_valid), 32'd0);
    endtask

    task automatic sendBeat(input logic [15:0] x, input logic [15:0] w, output bit ok);
        int   budget = 50;
        logic acc;
        ok       = 0;
        in_valid = 1'b1;
        x_in     = x;
        w_in     = w;
        while (budget > 0) begin
            acc = in_ready;
            @(negedge clk);
            if (acc) begin
                ok = 1;
                break;
            end
            budget--;
        end
        if (!ok) checkOutput("beat_timeout", 32'(in_ready), 32'd1);
    endtask

    task automatic checkReset();
        checkOutput("rst_in_ready", 32'(in_ready), 32'd0);
        checkOutput("rst_out_valid", 32'(out_valid), 32'd0);
        checkOutput("rst_busy", 32'(busy), 32'd0);
        checkOutput("rst_act_out", act_out, 32'd0);
        checkOutput("rst_idx_out", 32'(idx_out), 32'd0);
    endtask

    // Runs one neuron using xv/wv as its beat data.
    task automatic applyStimulus(input logic [6:0] n, input logic [15:0] b, input logic [6:0] idx,
                                 input int hold, input bit gaps, input bit ign_accum, input bit ign_done);
        int   neff;
        int   beats0;
        bit   ok;
        exp_t e;
        waitIdle();
        neff   = (n > 7'd64) ? 64 : int'(n);
        e.act  = model(neff, b);
        e.idx  = idx;
        e.hold = hold;
        sb.push_back(e);
        beats0 = beat_cnt;
        start  = 1'b1;
        n_in   = n;
        bias   = b;
        idx_in = idx;
        @(negedge clk);
        start  = 1'b0;
        n_in   = 7'($urandom);
        bias   = 16'($urandom);
        idx_in = 7'($urandom);
        if (neff == 0) begin
            checkOutput("zero_latency", 32'(out_valid), 32'd1);
            checkOutput("zero_no_ready", 32'(in_ready), 32'd0);
            return;
        end
        for (int k = 0; k < neff; k++) begin
            if (gaps) begin
                in_valid = 1'b0;
                x_in     = 16'($urandom);
                repeat ($urandom_range(0, 2)) @(negedge clk);
            end
            if (ign_accum && k == 1) begin
                in_valid = 1'b0;
                start    = 1'b1;
                idx_in   = idx ^ 7'h2A;
                @(negedge clk);
                start    = 1'b0;
            end
            sendBeat(xv[k], wv[k], ok);
            if (!ok) begin
                in_valid = 1'b0;
                return;
            end
        end
        // Keep offering an extra beat across one edge; it must be refused.
        x_in = 16'($urandom);
        w_in = 16'($urandom);
        checkOutput("ready_low_after_last", 32'(in_ready), 32'd0);
        checkOutput("valid_latency", 32'(out_valid), 32'd1);
        if (ign_done) begin
            start  = 1'b1;
            idx_in = idx ^ 7'h15;
        end
        @(negedge clk);
        start    = 1'b0;
        in_valid = 1'b0;
        checkOutput("beats_consumed", 32'(beat_cnt - beats0), 32'(neff));
    endtask

    initial begin
        bit ok;
        rst = 1'b1; start = 1'b0; n_in = '0; bias = '0; idx_in = '0;
        in_valid = 1'b0; x_in = '0; w_in = '0;
        repeat (2) @(negedge clk);
        checkReset();
        rst = 1'b0;

        xv[0] = 16'h0100; xv[1] = 16'h0200; xv[2] = 16'hFF00;
        for (int k = 0; k < 3; k++) wv[k] = 16'h0200;
        applyStimulus(7'd3, 16'h0080, 7'd5, 0, 0, 0, 0);

        applyStimulus(7'd0, 16'hFF80, 7'd9, 1, 0, 0, 0);

        for (int k = 0; k < 64; k++) begin xv[k] = 16'h7FFF; wv[k] = 16'h7FFF; end
        applyStimulus(7'd64, 16'h7FFF, 7'd1, 0, 0, 0, 0);
        for (int k = 0; k < 64; k++) xv[k] = 16'h8000;
        applyStimulus(7'd64, 16'h7FFF, 7'd2, 0, 0, 0, 0);

        for (int k = 0; k < 6; k++) begin xv[k] = 16'($urandom); wv[k] = 16'($urandom); end
        applyStimulus(7'd6, 16'($urandom), 7'd33, 5, 1, 1, 1);

        for (int k = 0; k < 128; k++) begin xv[k] = 16'($urandom); wv[k] = 16'($urandom); end
        applyStimulus(7'd100, 16'($urandom), 7'd77, 2, 1, 0, 0);

        for (int t = 0; t < 20; t++) begin
            for (int k = 0; k < 12; k++) begin xv[k] = 16'($urandom); wv[k] = 16'($urandom); end
            applyStimulus(7'($urandom_range(0, 12)), 16'($urandom), 7'($urandom),
                          $urandom_range(0, 3), 1'($urandom), 1'($urandom), 1'($urandom));
        end

        // Abort a neuron mid-way; it must leave no output and no residue.
        waitIdle();
        start = 1'b1; n_in = 7'd4; bias = 16'h1234; idx_in = 7'd3;
        @(negedge clk);
        start = 1'b0;
        sendBeat(16'h0400, 16'h0300, ok);
        sendBeat(16'h0500, 16'h0100, ok);
        in_valid = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        checkReset();
        rst = 1'b0;
        xv[0] = 16'h0100; wv[0] = 16'h0100;
        applyStimulus(7'd1, 16'h0000, 7'd4, 0, 0, 0, 0);

        waitIdle();
        checkOutput("sb_drained", 32'(sb.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
